// File: rtl/k12a_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : k12a_mem_arbiter
// Purpose  : Shares the asynchronous memory port between the k12a core and a
//            loader/debug port; the core keeps priority, the loader cannot starve.
// Revision : 1.0 - initial release
// ============================================================================
module k12a_mem_arbiter #(
  parameter int STROBE_CYCLES = 1,
  parameter int MAX_WAIT      = 8
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic        cpu_halted,
  input  logic        cpu_mem_enable,
  input  logic        cpu_mem_write,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  input  logic        ld_req,
  input  logic        ld_write,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  output logic        ld_ack,
  output logic [7:0]  ld_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        owner
);

  localparam logic [1:0] c_STROBE_LOAD = 2'(STROBE_CYCLES - 1);
  localparam logic [3:0] c_MAX_WAIT    = 4'(MAX_WAIT);

  typedef enum logic [2:0] {
    ST_CPU       = 3'd0,
    ST_LD_SETUP  = 3'd1,
    ST_LD_STROBE = 3'd2,
    ST_LD_READ   = 3'd3,
    ST_LD_HOLD   = 3'd4,
    ST_LD_RESP   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_ld_addr;
  logic [7:0]  r_ld_wdata;
  logic        r_ld_write;
  logic [1:0]  r_strobe_cnt;
  logic [3:0]  r_wait_cnt;
  logic        r_cooldown;
  logic        r_cpu_stall;
  logic [7:0]  r_ld_rdata;

  logic        w_grant;
  logic [15:0] w_mem_addr;
  logic [7:0]  w_mem_wdata;
  logic        w_mem_oe;
  logic        w_mem_we;

  // A halted core needs no breathing room, so cooldown only blocks a running one.
  assign w_grant = ld_req
                 & (cpu_halted | ~cpu_mem_enable | (r_wait_cnt == c_MAX_WAIT))
                 & (~r_cooldown | cpu_halted);

  always_comb begin
    w_next_state = r_state;
    w_mem_addr   = r_ld_addr;
    w_mem_wdata  = r_ld_wdata;
    w_mem_oe     = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      ST_CPU: begin
        w_mem_addr  = cpu_addr;
        w_mem_wdata = cpu_wdata;
        w_mem_oe    = cpu_mem_enable & ~cpu_mem_write;
        w_mem_we    = cpu_mem_enable & cpu_mem_write;
        if (w_grant) begin
          w_next_state = ST_LD_SETUP;
        end
      end
      ST_LD_SETUP: begin
        w_mem_oe     = ~r_ld_write;
        w_next_state = r_ld_write ? ST_LD_STROBE : ST_LD_READ;
      end
      ST_LD_STROBE: begin
        w_mem_we = 1'b1;
        if (r_strobe_cnt == 2'd0) begin
          w_next_state = ST_LD_HOLD;
        end
      end
      ST_LD_READ: begin
        w_mem_oe     = 1'b1;
        w_next_state = ST_LD_RESP;
      end
      ST_LD_HOLD: begin
        w_next_state = ST_LD_RESP;
      end
      ST_LD_RESP: begin
        w_next_state = ST_CPU;
      end
      default: begin
        w_next_state = ST_CPU;
      end
    endcase
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_state      <= ST_CPU;
      r_cpu_stall  <= 1'b0;
      r_ld_addr    <= 16'h0000;
      r_ld_wdata   <= 8'h00;
      r_ld_write   <= 1'b0;
      r_strobe_cnt <= 2'd0;
      r_wait_cnt   <= 4'd0;
      r_cooldown   <= 1'b0;
      r_ld_rdata   <= 8'h00;
    end else begin
      r_state     <= w_next_state;
      r_cpu_stall <= (w_next_state != ST_CPU);
      r_wait_cnt  <= 4'd0;
      case (r_state)
        ST_CPU: begin
          r_cooldown <= 1'b0;
          if (w_grant) begin
            r_ld_addr  <= ld_addr;
            r_ld_wdata <= ld_wdata;
            r_ld_write <= ld_write;
          end else if (ld_req && (r_wait_cnt != c_MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end else if (ld_req) begin
            r_wait_cnt <= r_wait_cnt;
          end
        end
        ST_LD_SETUP: begin
          r_strobe_cnt <= c_STROBE_LOAD;
        end
        ST_LD_STROBE: begin
          if (r_strobe_cnt != 2'd0) begin
            r_strobe_cnt <= r_strobe_cnt - 2'd1;
          end
        end
        ST_LD_READ: begin
          r_ld_rdata <= mem_rdata;
        end
        ST_LD_RESP: begin
          r_cooldown <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes are gated by reset so an aborted access never writes in the reset cycle.
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;
  assign mem_oe    = w_mem_oe & ~reset;
  assign mem_we    = w_mem_we & ~reset;
  assign cpu_rdata = mem_rdata;
  assign cpu_stall = r_cpu_stall;
  assign ld_ack    = (r_state == ST_LD_RESP) & ~reset;
  assign ld_rdata  = r_ld_rdata;
  assign owner     = (r_state != ST_CPU);

endmodule
`default_nettype wire

// File: tb/tb_k12a_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_k12a_mem_arbiter
// Purpose  : Directed self-checking bench for k12a_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k12a_mem_arbiter;

  logic        cpu_clock = 1'b0;
  logic        reset, cpu_halted, cpu_mem_enable, cpu_mem_write;
  logic [15:0] cpu_addr, ld_addr;
  logic [7:0]  cpu_wdata, ld_wdata;
  logic        ld_req, ld_write;

  logic [7:0]  cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic        cpu_stall, ld_ack, mem_oe, mem_we, owner;

  logic [7:0]  cpu_rdata3, ld_rdata3, mem_wdata3, mem_rdata3;
  logic [15:0] mem_addr3;
  logic        cpu_stall3, ld_ack3, mem_oe3, mem_we3, owner3;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;
  int n_wait, n_stall, n_we, n_oe, we_bad, ack_at;
  bit got_ack;
  bit gap_mode = 1'b0;

  always #5 cpu_clock = ~cpu_clock;

  // Asynchronous memory: combinational read, write committed at the clock edge.
  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata3 = mem[mem_addr3];
  always @(posedge cpu_clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  k12a_mem_arbiter dut (
    .cpu_clock(cpu_clock), .reset(reset), .cpu_halted(cpu_halted),
    .cpu_mem_enable(cpu_mem_enable), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .ld_req(ld_req), .ld_write(ld_write),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we), .owner(owner)
  );

  k12a_mem_arbiter #(.STROBE_CYCLES(3), .MAX_WAIT(8)) dut3 (
    .cpu_clock(cpu_clock), .reset(reset), .cpu_halted(cpu_halted),
    .cpu_mem_enable(cpu_mem_enable), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata3),
    .cpu_stall(cpu_stall3), .ld_req(ld_req), .ld_write(ld_write),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack3), .ld_rdata(ld_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .mem_oe(mem_oe3), .mem_we(mem_we3), .owner(owner3)
  );

  // Issues one loader transaction on dut and records what it observed.
  // n_wait counts unstalled cycles with ld_req high, including the grant cycle.
  task automatic run_ld(input logic wr, input logic [15:0] a, input logic [7:0] d,
                        input bit keep);
    ld_write = wr; ld_addr = a; ld_wdata = d; ld_req = 1'b1;
    n_wait = 0; n_stall = 0; n_we = 0; n_oe = 0; we_bad = 0; ack_at = -1; got_ack = 1'b0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (cpu_stall) n_stall++;
      else if (n_stall == 0) n_wait++;
      if (owner && mem_we) begin
        n_we++;
        if (mem_addr !== a || mem_wdata !== d) we_bad++;
      end
      if (owner && mem_oe) begin
        n_oe++;
        if (mem_addr !== a) we_bad++;
      end
      if (ld_ack) begin
        got_ack = 1'b1;
        ack_at  = n_stall;
        break;
      end
      @(negedge cpu_clock);
      if (gap_mode) cpu_mem_enable = ~cpu_mem_enable;
      #1;
    end
    if (!keep) ld_req = 1'b0;
    @(negedge cpu_clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_halted = 1'b0; cpu_mem_enable = 1'b1; cpu_mem_write = 1'b1;
    cpu_addr = 16'h0123; cpu_wdata = 8'h99;
    ld_req = 1'b0; ld_write = 1'b0; ld_addr = 16'h0000; ld_wdata = 8'h00;
    repeat (3) @(negedge cpu_clock);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", cpu_stall); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rst_owner got %b exp 0", owner); end
    checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", ld_ack); end
    checks++; if (ld_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", ld_rdata); end
    checks++; if (mem_we !== 1'b0 || mem_oe !== 1'b0) begin errors++; $display("FAIL rst_gate we/oe got %b%b exp 00", mem_we, mem_oe); end
    reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_oe !== 1'b0) begin errors++; $display("FAIL pass_wr we/oe got %b%b exp 10", mem_we, mem_oe); end
  endtask

  task automatic test_passthrough();
    checks++; if (mem_addr !== 16'h0123 || mem_wdata !== 8'h99) begin errors++; $display("FAIL pass_addr got %h/%h exp 0123/99", mem_addr, mem_wdata); end
    @(negedge cpu_clock);
    cpu_mem_write = 1'b0;
    #1;
    checks++; if (mem_oe !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL pass_rd we/oe got %b%b exp 01", mem_we, mem_oe); end
    checks++; if (cpu_rdata !== 8'h99) begin errors++; $display("FAIL pass_rdata got %h exp 99", cpu_rdata); end
    cpu_mem_enable = 1'b0;
    #1;
    checks++; if (mem_oe !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL pass_idle we/oe got %b%b exp 00", mem_we, mem_oe); end
    @(negedge cpu_clock);
  endtask

  task automatic test_halted_write();
    cpu_halted = 1'b1; cpu_mem_enable = 1'b0;
    run_ld(1'b1, 16'h8010, 8'hA5, 1'b0);
    checks++; if (!got_ack) begin errors++; $display("FAIL hw_ack got none exp ack"); end
    checks++; if (n_wait !== 1) begin errors++; $display("FAIL hw_wait got %0d exp 1", n_wait); end
    checks++; if (n_stall !== 4 || ack_at !== 4) begin errors++; $display("FAIL hw_stall got %0d/%0d exp 4/4", n_stall, ack_at); end
    checks++; if (n_we !== 1 || we_bad !== 0 || n_oe !== 0) begin errors++; $display("FAIL hw_strobe got we=%0d bad=%0d oe=%0d exp 1/0/0", n_we, we_bad, n_oe); end
    checks++; if (cpu_stall !== 1'b0 || ld_ack !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL hw_after got %b%b%b exp 000", cpu_stall, ld_ack, owner); end
    run_ld(1'b0, 16'h8010, 8'h00, 1'b0);
    checks++; if (!got_ack || n_wait !== 1 || n_stall !== 3) begin errors++; $display("FAIL hr_timing got ack=%b wait=%0d stall=%0d exp 1/1/3", got_ack, n_wait, n_stall); end
    checks++; if (n_oe !== 2 || n_we !== 0 || we_bad !== 0) begin errors++; $display("FAIL hr_oe got oe=%0d we=%0d bad=%0d exp 2/0/0", n_oe, n_we, we_bad); end
    checks++; if (ld_rdata !== 8'hA5) begin errors++; $display("FAIL hr_rdata got %h exp a5", ld_rdata); end
  endtask

  task automatic test_busy_core();
    cpu_halted = 1'b0; cpu_mem_enable = 1'b1; cpu_mem_write = 1'b1;
    cpu_addr = 16'h0140; cpu_wdata = 8'h3C;
    run_ld(1'b1, 16'h0250, 8'h77, 1'b0);
    checks++; if (!got_ack || n_wait !== 9) begin errors++; $display("FAIL busy_wr_wait got ack=%b wait=%0d exp 1/9", got_ack, n_wait); end
    checks++; if (n_stall !== 4 || n_we !== 1 || we_bad !== 0) begin errors++; $display("FAIL busy_wr_stall got %0d/%0d/%0d exp 4/1/0", n_stall, n_we, we_bad); end
    run_ld(1'b0, 16'h0250, 8'h00, 1'b0);
    checks++; if (!got_ack || n_wait !== 9 || n_stall !== 3) begin errors++; $display("FAIL busy_rd got ack=%b wait=%0d stall=%0d exp 1/9/3", got_ack, n_wait, n_stall); end
    checks++; if (ld_rdata !== 8'h77) begin errors++; $display("FAIL busy_rdata got %h exp 77", ld_rdata); end
    checks++; if (mem[16'h0140] !== 8'h3C) begin errors++; $display("FAIL busy_core_wr got %h exp 3c", mem[16'h0140]); end
  endtask

  task automatic test_core_gaps();
    cpu_halted = 1'b0; cpu_mem_enable = 1'b1; cpu_mem_write = 1'b1;
    cpu_addr = 16'h0360; cpu_wdata = 8'h5A;
    gap_mode = 1'b1;
    run_ld(1'b1, 16'h0470, 8'h6B, 1'b0);
    gap_mode = 1'b0;
    checks++; if (!got_ack || n_wait !== 2 || n_stall !== 4) begin errors++; $display("FAIL gap_timing got ack=%b wait=%0d stall=%0d exp 1/2/4", got_ack, n_wait, n_stall); end
    checks++; if (mem[16'h0360] !== 8'h5A || mem[16'h0470] !== 8'h6B) begin errors++; $display("FAIL gap_mem got %h/%h exp 5a/6b", mem[16'h0360], mem[16'h0470]); end
    cpu_mem_enable = 1'b1;
    run_ld(1'b0, 16'h0470, 8'h00, 1'b0);
    checks++; if (!got_ack || n_wait !== 9 || ld_rdata !== 8'h6B) begin errors++; $display("FAIL gap_clear got ack=%b wait=%0d rdata=%h exp 1/9/6b", got_ack, n_wait, ld_rdata); end
  endtask

  task automatic test_back_to_back();
    cpu_halted = 1'b1; cpu_mem_enable = 1'b0;
    run_ld(1'b1, 16'h8100, 8'h11, 1'b1);
    checks++; if (!got_ack) begin errors++; $display("FAIL b2b_h_first got none exp ack"); end
    run_ld(1'b1, 16'h8101, 8'h22, 1'b0);
    checks++; if (!got_ack || n_wait !== 1 || n_stall !== 4) begin errors++; $display("FAIL b2b_halted got ack=%b wait=%0d stall=%0d exp 1/1/4", got_ack, n_wait, n_stall); end
    cpu_halted = 1'b0;
    run_ld(1'b1, 16'h8102, 8'h33, 1'b1);
    run_ld(1'b1, 16'h8103, 8'h44, 1'b0);
    checks++; if (!got_ack || n_wait !== 2 || n_stall !== 4) begin errors++; $display("FAIL b2b_running got ack=%b wait=%0d stall=%0d exp 1/2/4", got_ack, n_wait, n_stall); end
    checks++; if (mem[16'h8100] !== 8'h11 || mem[16'h8101] !== 8'h22 || mem[16'h8103] !== 8'h44) begin errors++; $display("FAIL b2b_mem got %h/%h/%h exp 11/22/44", mem[16'h8100], mem[16'h8101], mem[16'h8103]); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int acks;
    found = 1'b0; acks = 0;
    cpu_halted = 1'b1; cpu_mem_enable = 1'b0;
    ld_write = 1'b1; ld_addr = 16'h8200; ld_wdata = 8'hEE; ld_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge cpu_clock);
      if (owner && mem_we) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_strobe got none exp strobe"); end
    reset = 1'b1; ld_req = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || ld_ack !== 1'b0) begin errors++; $display("FAIL rmid_we got we=%b ack=%b exp 0/0", mem_we, ld_ack); end
    @(negedge cpu_clock);
    checks++; if (cpu_stall !== 1'b0 || owner !== 1'b0 || ld_ack !== 1'b0 || mem_oe !== 1'b0) begin errors++; $display("FAIL rmid_outs got %b%b%b%b exp 0000", cpu_stall, owner, ld_ack, mem_oe); end
    checks++; if (ld_rdata !== 8'h00) begin errors++; $display("FAIL rmid_rdata got %h exp 00", ld_rdata); end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge cpu_clock);
      if (ld_ack || cpu_stall) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rmid_noack got %0d exp 0", acks); end
  endtask

  task automatic test_strobe3();
    int s3, w3, bad3, at3;
    s3 = 0; w3 = 0; bad3 = 0; at3 = -1;
    reset = 1'b1;
    repeat (2) @(negedge cpu_clock);
    reset = 1'b0; cpu_halted = 1'b1; cpu_mem_enable = 1'b0;
    ld_write = 1'b1; ld_addr = 16'h9000; ld_wdata = 8'hC3; ld_req = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (cpu_stall3) s3++;
      if (owner3 && mem_we3) begin
        w3++;
        if (mem_addr3 !== 16'h9000 || mem_wdata3 !== 8'hC3) bad3++;
      end
      if (ld_ack3) begin at3 = s3; break; end
      @(negedge cpu_clock);
      #1;
    end
    ld_req = 1'b0;
    checks++; if (w3 !== 3 || bad3 !== 0) begin errors++; $display("FAIL s3_we got %0d/%0d exp 3/0", w3, bad3); end
    checks++; if (at3 !== 6) begin errors++; $display("FAIL s3_ack got %0d exp 6", at3); end
    @(negedge cpu_clock);
    checks++; if (cpu_stall3 !== 1'b0 || ld_ack3 !== 1'b0) begin errors++; $display("FAIL s3_after got %b%b exp 00", cpu_stall3, ld_ack3); end
    repeat (8) @(negedge cpu_clock);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_halted_write();
    test_busy_core();
    test_core_gaps();
    test_back_to_back();
    test_reset_mid();
    test_strobe3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k12a_mem_arbiter.md
# k12a_mem_arbiter

Shares the single asynchronous memory port (ROM/RAM behind the address and data buses) between the k12a core and an external loader/debug port. The core keeps priority and runs at full speed. A loader request is granted at a core cycle boundary, and the core is frozen through `cpu_stall` while the arbiter sequences a setup/strobe/hold memory cycle for the loader. A bounded wait counter guarantees the loader cannot be starved by a core that accesses memory continuously.

## Interface
- `STROBE_CYCLES`, default 1: width of the `mem_we` pulse for loader writes, legal range 1-4.
- `MAX_WAIT`, default 8: number of consecutive ungranted `ld_req` cycles after which the core is stalled regardless of its activity. Legal range 1-15.

Ports:
- `cpu_clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_halted` in 1: core is in its HALT state.
- `cpu_mem_enable` in 1: core is accessing memory this cycle.
- `cpu_mem_write` in 1: 1 = write, 0 = read. Only meaningful while `cpu_mem_enable` is high.
- `cpu_addr` in 16: core address.
- `cpu_wdata` in 8: core write data.
- `cpu_rdata` out 8: read data to the core.
- `cpu_stall` out 1: registered; while high, the core holds its state and all registers.
- `ld_req` in 1: loader request. Held high with stable `ld_*` inputs until `ld_ack`.
- `ld_write` in 1: 1 = write, 0 = read.
- `ld_addr` in 16: loader address.
- `ld_wdata` in 8: loader write data.
- `ld_ack` out 1: one-cycle completion pulse.
- `ld_rdata` out 8: loader read result. Valid from the `ld_ack` cycle until the next loader read completes.
- `mem_addr` out 16, `mem_wdata` out 8: memory address and write data.
- `mem_rdata` in 8: memory read data.
- `mem_oe` out 1, `mem_we` out 1: memory output enable and write enable, both active-high.
- `owner` out 1: 0 = core, 1 = loader. Intended for debug/LED use.

## Operation
FSM states: CPU, LD_SETUP, LD_STROBE, LD_READ, LD_HOLD, LD_RESP.

**CPU state**
- Outputs pass through combinationally:
  - `mem_addr` = `cpu_addr`, `mem_wdata` = `cpu_wdata`.
  - `mem_oe` = `cpu_mem_enable & !cpu_mem_write`.
  - `mem_we` = `cpu_mem_enable & cpu_mem_write`.
- `cpu_stall` = 0 and `owner` = 0.
- Grant condition, evaluated each cycle: `ld_req & (cpu_halted | !cpu_mem_enable | wait_cnt == MAX_WAIT) & !cooldown`.
- On grant:
  - latch `ld_addr`, `ld_wdata`, `ld_write` into internal registers;
  - go to LD_SETUP;
  - set `cpu_stall` = 1 at the same edge.
- The core's current cycle always completes first, because the grant takes effect only at the edge.

**wait_cnt (4 bits)**
- Increments in CPU state while `ld_req` is high and not granted.
- Saturates at `MAX_WAIT`.
- Clears on grant, and whenever `ld_req` is low.

**cooldown (1 bit)**
- Set when leaving LD_RESP; cleared after one CPU-state cycle.
- Ensures the core gets at least one unstalled cycle between loader accesses.
- Ignored while `cpu_halted` is high, so back-to-back loader accesses are allowed on a halted core.

**Loader states**
- In all of them: `owner` = 1, `cpu_stall` = 1, and `mem_addr`/`mem_wdata` come from the latched loader registers.
- Write sequence: LD_SETUP (we=0, oe=0) → LD_STROBE for `STROBE_CYCLES` cycles (we=1) → LD_HOLD (we=0, data still driven) → LD_RESP.
- Read sequence: LD_SETUP (oe=1) → LD_READ (oe=1, `ld_rdata` <= `mem_rdata` at the end of the cycle) → LD_RESP.
- LD_RESP: `ld_ack` = 1, `mem_oe` = `mem_we` = 0. Next state is CPU, and `cpu_stall` drops at that edge.
- `ld_req` deasserted early (protocol violation): the latched transaction still completes and is acked.

**Other rules**
- `cpu_rdata` = `mem_rdata` at all times. It is meaningful only in CPU state.
- Strobe counter is 2 bits and is loaded with `STROBE_CYCLES-1` on entry to LD_STROBE.

## Timing
- **Reset values:** state = CPU, `cpu_stall` 0, `owner` 0, `ld_ack` 0, `ld_rdata` 8'h00, `wait_cnt` 0, `cooldown` 0.
- **Reset gating:** while `reset` is high, `mem_we` and `mem_oe` are forced to 0 combinationally.
- **Reset mid-loader-access:** the access aborts at the reset edge, with no `ld_ack`. `mem_we` is never asserted in the reset cycle.
- **Loader write latency:** grant edge to `ld_ack` cycle = 2 + `STROBE_CYCLES` stalled cycles, then `ld_ack`. That is 4 stalled cycles in total at the default `STROBE_CYCLES`.
- **Loader read latency:** 3 stalled cycles (SETUP, READ, RESP).
- **Worst-case loader wait on a busy core:** `MAX_WAIT` + 1 cycles from `ld_req` rising to grant.
- **Simultaneous core access and grant cycle:** the core access is performed with pass-through signals. The loader starts on the following cycle.
- **Clean `mem_we` pulse:** `mem_we` never goes high in the same cycle that `mem_addr` changes source.
- **`ld_req` rising while `cpu_halted`:** grant at the next edge.

## Test plan
- **Idle core, halted:** `ld_req` write, addr 16'h8010, data 8'hA5, `STROBE_CYCLES` = 1.
  - `mem_we` high for exactly 1 cycle with `mem_addr` = 8010 and `mem_wdata` = A5.
  - `ld_ack` 4 cycles after grant.
  - A following read of 8010 returns `ld_rdata` = A5.
- **Busy core:** `cpu_mem_enable` held high every cycle, `ld_req` raised.
  - Grant occurs after exactly `MAX_WAIT` (8) waiting cycles.
  - `cpu_stall` is high for 4 cycles for a write and 3 cycles for a read.
- **Core gaps:** core has `cpu_mem_enable` = 0 on alternate cycles.
  - Grant on the first gap cycle; core accesses before the grant are unaffected; `wait_cnt` clears.
- **Back-to-back loader writes:**
  - Halted core: no idle cycle between them.
  - Running core: exactly one unstalled cycle between `ld_ack` and the next grant.
- **Reset mid-access:** assert `reset` during LD_STROBE.
  - `mem_we` drops in the same cycle; no `ld_ack`; all outputs at their reset values next cycle.
- **`STROBE_CYCLES` = 3:** `mem_we` is high for exactly 3 cycles, and `ld_ack` arrives 6 cycles after grant.
